beam_trigger_rate_counter: RTL and testbench



---
 rtl/beam_trigger_rate_counter.sv | 164 ++++++++++++++++
 tb/tb_beam_trigger_rate_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_trigger_rate_counter.sv
// -----------------------------------------------------------------------------
// beam_trigger_rate_counter
//
// Per-beam trigger rate scaler in the aclk domain. A start request opens a
// counting window of PERIOD_CLKS clocks. Every beam has a holdoff (dead time)
// after each counted trigger. At the end of the window all beam counts are
// latched into a stable output bank and done_o pulses for one cycle, so the
// wishbone-side readout can capture count_o through a flag crossing.
//
// Parameters
//   NBEAMS       number of beam trigger inputs
//   PERIOD_CLKS  window length in clk_i cycles (>= 2)
//   HOLDOFF_CLKS cycles a beam is blind after a counted trigger (0 = none)
//   COUNT_BITS   width of each beam count (saturating)
//
// Ports
//   clk_i      aclk-domain clock, the only clock
//   rst_i      synchronous active-high reset
//   trigger_i  per-beam trigger level, sampled every clock edge
//   start_i    single-cycle pulse: clear live counts, start/restart the window
//   busy_o     high while the window is running
//   done_o     one-cycle pulse; count_o already holds the new counts
//   count_o    latched counts of the last completed window
// -----------------------------------------------------------------------------
module beam_trigger_rate_counter #(
    parameter int NBEAMS       = 2,
    parameter int PERIOD_CLKS  = 375000000,
    parameter int HOLDOFF_CLKS = 4,
    parameter int COUNT_BITS   = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NBEAMS-1:0]                    trigger_i,
    input  logic                                 start_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [NBEAMS-1:0][COUNT_BITS-1:0]    count_o
);

    localparam int TIMER_BITS = $clog2(PERIOD_CLKS);
    localparam int HOLD_BITS  = (HOLDOFF_CLKS > 0) ? $clog2(HOLDOFF_CLKS + 1) : 1;

    localparam logic [TIMER_BITS-1:0] TIMER_PENULT = TIMER_BITS'(PERIOD_CLKS - 2);
    localparam logic [HOLD_BITS-1:0]  HOLD_LOAD    = HOLD_BITS'(HOLDOFF_CLKS);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t                               state_q;
    state_t                               state_d;
    logic [TIMER_BITS-1:0]                timer_q;
    logic                                 timer_last_q;   // timer_q == PERIOD_CLKS-1
    logic [NBEAMS-1:0][HOLD_BITS-1:0]     holdoff_q;
    logic [NBEAMS-1:0][COUNT_BITS-1:0]    live_q;
    logic [NBEAMS-1:0][COUNT_BITS-1:0]    live_d;
    logic [NBEAMS-1:0]                    qualify;
    logic                                 window_end;

    // -------------------------------------------------------------------------
    // Trigger qualification: a beam is only seen when its holdoff has expired.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            qualify[b] = trigger_i[b] && (holdoff_q[b] == '0);
        end
    end

    // Last COUNT cycle without a restart: the window closes at this edge.
    assign window_end = (state_q == S_COUNT) && timer_last_q && !start_i;

    // -------------------------------------------------------------------------
    // FSM next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latch).
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_COUNT;
            end
            S_COUNT: begin
                busy_o = 1'b1;
                if (start_i)           state_d = S_COUNT;
                else if (timer_last_q) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = start_i ? S_COUNT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Live count next value. A start clears the counts and wins over a
    // coincident qualify, so that trigger belongs to no window.
    // -------------------------------------------------------------------------
    always_comb begin
        live_d = live_q;
        for (int b = 0; b < NBEAMS; b++) begin
            if (start_i) begin
                live_d[b] = '0;
            end else if ((state_q == S_COUNT) && qualify[b] && (live_q[b] != COUNT_MAX)) begin
                live_d[b] = live_q[b] + COUNT_BITS'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State, timer, holdoff and count registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            timer_last_q <= 1'b0;
            holdoff_q    <= '0;
            live_q       <= '0;
            count_o      <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;

            // The terminal compare is done one cycle early and registered so
            // the FSM never waits on a wide equality in the same cycle.
            if (start_i) begin
                timer_q      <= '0;
                timer_last_q <= 1'b0;
            end else if (state_q == S_COUNT) begin
                timer_q      <= timer_q + TIMER_BITS'(1);
                timer_last_q <= (timer_q == TIMER_PENULT);
            end else begin
                timer_q      <= '0;
                timer_last_q <= 1'b0;
            end

            // Holdoff runs in every state: dead time is a property of the
            // detector, not of the counting window.
            for (int b = 0; b < NBEAMS; b++) begin
                if (qualify[b]) begin
                    holdoff_q[b] <= HOLD_LOAD;
                end else if (holdoff_q[b] != '0) begin
                    holdoff_q[b] <= holdoff_q[b] - HOLD_BITS'(1);
                end
            end

            // Latch on entry to DONE using live_d, which already includes a
            // qualify in the last COUNT cycle; count_o is valid while done_o.
            if (window_end) begin
                count_o <= live_d;
            end
        end
    end

endmodule

// File: tb/tb_beam_trigger_rate_counter.sv
// -----------------------------------------------------------------------------
// tb_beam_trigger_rate_counter
//
// Directed bench for beam_trigger_rate_counter. Stimulus pushes the expected
// window result (closing edge index and per-beam counts) into a queue when a
// window is started; a monitor per DUT pops and compares whenever done_o is
// seen. A second instance with 4-bit counts and no holdoff covers saturation.
// -----------------------------------------------------------------------------
module tb_beam_trigger_rate_counter;

    localparam int P = 100;

    typedef struct {
        int          end_edge;
        logic [31:0] c0;
        logic [31:0] c1;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        trig;
    logic              start;
    logic              busy;
    logic              done;
    logic [1:0][31:0]  count;

    logic [1:0]        trig_s;
    logic              start_s;
    logic              busy_s;
    logic              done_s;
    logic [1:0][3:0]   count_s;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t q_main[$];
    exp_t q_sat[$];
    exp_t em;
    exp_t es;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    beam_trigger_rate_counter #(
        .NBEAMS(2), .PERIOD_CLKS(P), .HOLDOFF_CLKS(4), .COUNT_BITS(32)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .trigger_i(trig), .start_i(start),
        .busy_o(busy), .done_o(done), .count_o(count)
    );

    beam_trigger_rate_counter #(
        .NBEAMS(2), .PERIOD_CLKS(P), .HOLDOFF_CLKS(0), .COUNT_BITS(4)
    ) u_sat (
        .clk_i(clk), .rst_i(rst), .trigger_i(trig_s), .start_i(start_s),
        .busy_o(busy_s), .done_o(done_s), .count_o(count_s)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Start pulse sampled at one edge; k returns that edge index.
    task automatic do_start(input bit sat, output int k);
        @(negedge clk);
        if (sat) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start   = 1'b0;
        k = cyc;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Single-cycle pulse in the cycle that follows edge n (timer n-k).
    task automatic pulse(input int b, input int n);
        wait_until(n);
        trig[b] = 1'b1;
        @(negedge clk);
        trig[b] = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Monitors
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_done", 1, 0);
            end else begin
                em = q_main.pop_front();
                check("main_done_edge", cyc, em.end_edge);
                check("main_count0", count[0], em.c0);
                check("main_count1", count[1], em.c1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_s) begin
            if (q_sat.size() == 0) begin
                check("sat_unexpected_done", 1, 0);
            end else begin
                es = q_sat.pop_front();
                check("sat_done_edge", cyc, es.end_edge);
                check("sat_count0", count_s[0], es.c0);
                check("sat_count1", count_s[1], es.c1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int k;
        int k2;
        int nb;

        rst = 1'b1; start = 1'b0; trig = '0; start_s = 1'b0; trig_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count0", count[0], 0);
        check("rst_count1", count[1], 0);
        check("rst_sat_busy", busy_s, 0);
        check("rst_sat_count0", count_s[0], 0);

        // Beam 0 held high for the whole window: counted every 5 cycles.
        do_start(1'b0, k);
        q_main.push_back('{k + P, 32'd20, 32'd0});
        trig[0] = 1'b1;
        nb = 0;
        repeat (P) begin
            nb += int'(busy);
            @(negedge clk);
        end
        trig[0] = 1'b0;
        check("busy_cycles", nb, P);
        check("busy_low_in_done", busy, 0);
        wait_until(k + P + 3);

        // Second pulse inside holdoff is ignored.
        do_start(1'b0, k);
        q_main.push_back('{k + P, 32'd0, 32'd1});
        pulse(1, k + 10);
        pulse(1, k + 12);
        wait_until(k + P + 3);

        // Second pulse exactly when holdoff expires is counted.
        do_start(1'b0, k);
        q_main.push_back('{k + P, 32'd0, 32'd2});
        pulse(1, k + 10);
        pulse(1, k + 15);
        wait_until(k + P + 3);

        // Pulse at timer 99 counted; pulse in DONE arms holdoff only; start in
        // DONE honoured; pulse at timer 2 of the new window still in holdoff.
        do_start(1'b0, k);
        q_main.push_back('{k + P, 32'd1, 32'd0});
        wait_until(k + 99);
        trig[0] = 1'b1;
        @(negedge clk);
        trig[0] = 1'b0;
        trig[1] = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        trig[1] = 1'b0;
        start   = 1'b0;
        k2 = cyc;
        q_main.push_back('{k2 + P, 32'd0, 32'd0});
        pulse(1, k2 + 2);
        wait_until(k2 + P + 3);

        // Restart at timer 50 after 7 counted triggers; 3 more afterwards.
        do_start(1'b0, k);
        for (int i = 0; i < 7; i++) pulse(0, k + 5 * i);
        wait_until(k + 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k2 = cyc;
        q_main.push_back('{k2 + P, 32'd3, 32'd0});
        pulse(0, k2 + 10);
        pulse(0, k2 + 20);
        pulse(0, k2 + 30);
        wait_until(k2 + P + 3);

        // Start coincident with the last COUNT cycle: restart wins, count_o holds.
        do_start(1'b0, k);
        pulse(1, k + 3);
        wait_until(k + 99);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k2 = cyc;
        check("last_cycle_restart_done", done, 0);
        check("last_cycle_restart_busy", busy, 1);
        check("last_cycle_hold_count0", count[0], 3);
        check("last_cycle_hold_count1", count[1], 0);
        q_main.push_back('{k2 + P, 32'd0, 32'd1});
        pulse(1, k2 + 20);
        wait_until(k2 + P + 3);

        // Reset mid-window: aborted, outputs cleared, no done.
        do_start(1'b0, k);
        pulse(0, k + 5);
        wait_until(k + 60);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count0", count[0], 0);
        check("midrst_count1", count[1], 0);
        wait_until(k + P + 10);

        // Saturation: 4-bit counts, no holdoff, continuous trigger.
        do_start(1'b1, k);
        q_sat.push_back('{k + P, 32'd15, 32'd0});
        trig_s[0] = 1'b1;
        wait_until(k + P);
        trig_s[0] = 1'b0;
        wait_until(k + P + 3);

        while (q_main.size() != 0) begin
            em = q_main.pop_front();
            check("main_missing_done", 0, em.end_edge);
        end
        while (q_sat.size() != 0) begin
            es = q_sat.pop_front();
            check("sat_missing_done", 0, es.end_edge);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
